// File: rtl/ex_xalu_if.sv
// Handshake and data bundle between the EX stage and the multiply/divide unit.
interface ex_xalu_if;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        flush;
  logic        busy;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] XALUOUT;

  modport master (
    output op, A, B, flush,
    input  busy, start, HI, LO, XALUOUT
  );

  modport slave (
    input  op, A, B, flush,
    output busy, start, HI, LO, XALUOUT
  );
endinterface

// File: rtl/ex_xalu.sv
// Multi-cycle multiply/divide unit of the EX stage, owner of the HI/LO registers.
// The full 64-bit result is computed in the start cycle and parked in pending
// registers; the busy window only models the latency seen by hazard control.
module ex_xalu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  ex_xalu_if.slave  bus
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic        pend_wr;

  logic        busy;
  logic        start;
  logic        commit;
  logic        is_arith;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] den_u;
  logic [31:0] den_s;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_mag;
  logic [31:0] sr_mag;
  logic [31:0] sq;
  logic [31:0] sr;

  logic [63:0] result;
  logic        result_wr;
  logic [3:0]  run_len;

  assign busy     = (state == RUN);
  assign is_arith = (bus.op >= OP_MULT) && (bus.op <= OP_DIVU);
  assign start    = is_arith && !busy && !bus.flush;
  assign commit   = busy && (cnt == 4'd1);

  // Arithmetic cores; signed divide works on magnitudes so INT_MIN / -1 wraps cleanly.
  always_comb begin
    prod_s = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
    prod_u = {32'd0, bus.A} * {32'd0, bus.B};
    abs_a  = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
    abs_b  = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
    den_u  = (bus.B == 32'd0) ? 32'd1 : bus.B;
    den_s  = (abs_b == 32'd0) ? 32'd1 : abs_b;
    uq     = bus.A / den_u;
    ur     = bus.A % den_u;
    sq_mag = abs_a / den_s;
    sr_mag = abs_a % den_s;
    sq     = (bus.A[31] ^ bus.B[31]) ? (~sq_mag + 32'd1) : sq_mag;
    sr     = bus.A[31] ? (~sr_mag + 32'd1) : sr_mag;
  end

  // Pick the result, latency and write-enable for the op being started; a zero divisor leaves HI/LO alone.
  always_comb begin
    result    = prod_s;
    result_wr = 1'b1;
    run_len   = 4'(MULT_CYCLES);
    case (bus.op)
      OP_MULTU: result = prod_u;
      OP_DIV: begin
        result    = {sr, sq};
        result_wr = (bus.B != 32'd0);
        run_len   = 4'(DIV_CYCLES);
      end
      OP_DIVU: begin
        result    = {ur, uq};
        result_wr = (bus.B != 32'd0);
        run_len   = 4'(DIV_CYCLES);
      end
      default: ;
    endcase
  end

  // Next-state logic: leave IDLE on an accepted start, leave RUN when the last busy cycle commits.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN:  if (commit) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Counter, pending result and architectural HI/LO updates.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 4'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else if (start) begin
      cnt     <= run_len;
      pend_hi <= result[63:32];
      pend_lo <= result[31:0];
      pend_wr <= result_wr;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (commit && pend_wr) begin
        hi_q <= pend_hi;
        lo_q <= pend_lo;
      end
    end else if (!bus.flush) begin
      if (bus.op == OP_MTHI) hi_q <= bus.A;
      if (bus.op == OP_MTLO) lo_q <= bus.A;
    end
  end

  // MFHI/MFLO read path straight off the current registers.
  always_comb begin
    bus.XALUOUT = 32'd0;
    if (bus.op == OP_MFHI) bus.XALUOUT = hi_q;
    if (bus.op == OP_MFLO) bus.XALUOUT = lo_q;
  end

  assign bus.busy  = busy;
  assign bus.start = start;
  assign bus.HI    = hi_q;
  assign bus.LO    = lo_q;

endmodule

// File: tb/tb_ex_xalu.sv
// Self-checking bench for ex_xalu: a cycle-level reference model tracks HI/LO and
// the remaining busy cycles, and directed vectors pin it with literal results.
module tb_ex_xalu;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  ex_xalu_if bus ();

  ex_xalu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [31:0] p_hi = 32'd0;
  logic [31:0] p_lo = 32'd0;
  logic        p_wr = 1'b0;
  int          remaining = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: computes results with plain integer arithmetic and counts down the busy window.
  always @(posedge clk or negedge reset) begin
    longint sa, sb, q, r;
    logic [63:0] p;
    if (!reset) begin
      m_hi = 32'd0; m_lo = 32'd0; p_hi = 32'd0; p_lo = 32'd0;
      p_wr = 1'b0; remaining = 0;
    end else if (remaining > 0) begin
      remaining--;
      if (remaining == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (!bus.flush) begin
      case (bus.op)
        4'd1: begin
          p = 64'(longint'($signed(bus.A)) * longint'($signed(bus.B)));
          p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1'b1; remaining = 5;
        end
        4'd2: begin
          p = {32'd0, bus.A} * {32'd0, bus.B};
          p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1'b1; remaining = 5;
        end
        4'd3, 4'd4: begin
          if (bus.op == 4'd3) begin
            sa = longint'($signed(bus.A));
            sb = longint'($signed(bus.B));
          end else begin
            sa = longint'({32'd0, bus.A});
            sb = longint'({32'd0, bus.B});
          end
          p_wr = (sb != 0);
          if (sb != 0) begin
            q = sa / sb;
            r = sa % sb;
            p_hi = r[31:0];
            p_lo = q[31:0];
          end
          remaining = 10;
        end
        4'd5: m_hi = bus.A;
        4'd6: m_lo = bus.A;
        default: ;
      endcase
    end
  end

  // Compare every output against the model shortly after each rising edge.
  always @(posedge clk) begin
    logic        exp_busy;
    logic        exp_start;
    logic [31:0] exp_x;
    #1;
    exp_busy  = (remaining > 0);
    exp_start = (bus.op >= 4'd1) && (bus.op <= 4'd4) && !exp_busy && !bus.flush;
    exp_x     = (bus.op == 4'd7) ? m_hi : (bus.op == 4'd8) ? m_lo : 32'd0;
    chk("cyc_busy",  {31'd0, bus.busy},  {31'd0, exp_busy});
    chk("cyc_start", {31'd0, bus.start}, {31'd0, exp_start});
    chk("cyc_hi",    bus.HI,  m_hi);
    chk("cyc_lo",    bus.LO,  m_lo);
    chk("cyc_xalu",  bus.XALUOUT, exp_x);
  end

  // Drive one op for exactly one cycle; caller is positioned at a falling edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic fl);
    bus.op = op; bus.A = a; bus.B = b; bus.flush = fl;
    @(negedge clk);
    bus.op = 4'd0; bus.flush = 1'b0;
  endtask

  // Count falling edges with busy high, bounded so a stuck unit cannot hang the run.
  task automatic waitIdle(output int n);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    if (n >= 40) chk("busy_timeout", 32'(n), 32'd0);
  endtask

  // Compare DUT and model registers with hand-computed values.
  task automatic checkOutput(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    chk({name, "_hi"}, bus.HI, exp_hi);
    chk({name, "_lo"}, bus.LO, exp_lo);
    chk({name, "_model_hi"}, m_hi, exp_hi);
    chk({name, "_model_lo"}, m_lo, exp_lo);
  endtask

  initial begin
    int n;
    bus.op = 4'd0; bus.A = 32'd0; bus.B = 32'd0; bus.flush = 1'b0;

    // Reset state and MFHI/MFLO on cleared registers.
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    bus.op = 4'd7; #1 chk("rst_mfhi", bus.XALUOUT, 32'd0);
    bus.op = 4'd8; #1 chk("rst_mflo", bus.XALUOUT, 32'd0);
    bus.op = 4'd0;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // MULT and MULTU.
    applyStimulus(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    waitIdle(n);
    chk("mult_busy_len", 32'(n), 32'd5);
    checkOutput("mult", 32'hFFFFFFFF, 32'hFFFFFFFA);
    applyStimulus(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0);
    waitIdle(n);
    checkOutput("multu", 32'h00000001, 32'hFFFFFFFE);

    // DIV, DIVU and the INT_MIN / -1 corner.
    applyStimulus(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
    waitIdle(n);
    chk("div_busy_len", 32'(n), 32'd10);
    checkOutput("div", 32'hFFFFFFFF, 32'hFFFFFFFD);
    applyStimulus(4'd4, 32'd7, 32'd2, 1'b0);
    waitIdle(n);
    checkOutput("divu", 32'd1, 32'd3);
    applyStimulus(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    waitIdle(n);
    checkOutput("div_ovf", 32'd0, 32'h80000000);

    // Divide by zero keeps HI/LO after a full busy window.
    applyStimulus(4'd5, 32'h11, 32'd0, 1'b0);
    applyStimulus(4'd6, 32'h22, 32'd0, 1'b0);
    applyStimulus(4'd4, 32'd5, 32'd0, 1'b0);
    waitIdle(n);
    chk("divz_busy_len", 32'(n), 32'd10);
    checkOutput("divz", 32'h11, 32'h22);

    // Flushed MULT and flushed MTLO have no effect.
    bus.op = 4'd1; bus.A = 32'd3; bus.B = 32'd4; bus.flush = 1'b1;
    #1 chk("flush_start", {31'd0, bus.start}, 32'd0);
    @(negedge clk);
    bus.op = 4'd0; bus.flush = 1'b0;
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    applyStimulus(4'd6, 32'h99, 32'd0, 1'b1);
    checkOutput("flush", 32'h11, 32'h22);

    // Flush during RUN does not abort the operation in flight.
    applyStimulus(4'd1, 32'd3, 32'd4, 1'b0);
    bus.flush = 1'b1;
    repeat (2) @(negedge clk);
    bus.flush = 1'b0;
    waitIdle(n);
    chk("flush_run_len", 32'(n), 32'd3);
    checkOutput("flush_run", 32'd0, 32'd12);

    // Ops arriving while busy are ignored; a start in the first idle cycle is accepted.
    applyStimulus(4'd1, 32'h10, 32'h10, 1'b0);
    applyStimulus(4'd5, 32'hDEAD, 32'd0, 1'b0);
    applyStimulus(4'd1, 32'd5, 32'd5, 1'b0);
    waitIdle(n);
    checkOutput("interlock", 32'd0, 32'h100);
    applyStimulus(4'd1, 32'd7, 32'd6, 1'b0);
    chk("b2b_busy", {31'd0, bus.busy}, 32'd1);
    waitIdle(n);
    chk("b2b_len", 32'(n), 32'd5);
    checkOutput("b2b", 32'd0, 32'h2A);

    // Reset mid-RUN clears everything at once and nothing commits later.
    applyStimulus(4'd1, 32'd9, 32'd9, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1 chk("rst_run_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_run", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_run_late_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_run_late", 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
